// File: rtl/dot_product_pkg.sv
// Shared types and width helpers for the multi-lane dot-product engine.
package dot_product_pkg;

    localparam int unsigned WIDTH_DEF   = 8;
    localparam int unsigned LANES_DEF   = 4;
    localparam int unsigned MAX_LEN_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    function automatic int unsigned acc_width(input int unsigned width, input int unsigned max_len);
        return 2 * width + $clog2(max_len) + 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/dot_product_lanes_mult.sv
// One masked, mode-aware WIDTH x WIDTH multiplier lane with registered product.
module dot_lane_mult #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned PW    = 2 * WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mask,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic signed [PW-1:0] prod
);

    logic signed [WIDTH:0]  a_ext;
    logic signed [WIDTH:0]  b_ext;
    logic signed [PW-1:0]   a_w;
    logic signed [PW-1:0]   b_w;

    // One extra bit makes unsigned operands non-negative in signed arithmetic
    assign a_ext = {signed_mode & a[WIDTH-1], a};
    assign b_ext = {signed_mode & b[WIDTH-1], b};
    assign a_w   = PW'(a_ext);
    assign b_w   = PW'(b_ext);

    always_ff @(posedge clk) begin
        if (rst) begin
            prod <= '0;
        end else begin
            prod <= (en && mask) ? a_w * b_w : '0;
        end
    end

endmodule

// File: rtl/dot_product_lanes.sv
// Streaming LANES-wide dot-product engine: multiply, lane sum, accumulate, hold result.
module dot_product_lanes
    import dot_product_pkg::*;
#(
    parameter  int unsigned WIDTH   = WIDTH_DEF,
    parameter  int unsigned LANES   = LANES_DEF,
    parameter  int unsigned MAX_LEN = MAX_LEN_DEF,
    localparam int unsigned ACC_W   = acc_width(WIDTH, MAX_LEN),
    localparam int unsigned CNT_W   = cnt_width(MAX_LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [LANES-1:0]       in_mask,
    input  logic                   in_last,
    input  logic                   in_signed,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_result,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_len_err
);

    localparam int unsigned PW  = 2 * WIDTH + 1;
    localparam int unsigned PCW = CNT_W + 1;

    state_t               state;
    logic                 mode_r;
    logic                 accept_c;
    logic                 mode_c;
    logic                 v1, l1, v2, l2;
    logic signed [PW-1:0] prod [LANES];
    logic [ACC_W-1:0]     lane_sum_c;
    logic [ACC_W-1:0]     lane_sum_r;
    logic [PCW-1:0]       pop_c;
    logic [PCW-1:0]       cnt_sum_c;
    logic [CNT_W-1:0]     cnt_sat_c;

    assign accept_c = in_valid && in_ready;
    // Mode comes from the first beat; later beats use the latched copy
    assign mode_c   = (state == IDLE) ? in_signed : mode_r;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dot_lane_mult #(.WIDTH(WIDTH)) u_mult (
            .clk         (clk),
            .rst         (rst),
            .en          (accept_c),
            .mask        (in_mask[g]),
            .signed_mode (mode_c),
            .a           (in_a[g*WIDTH +: WIDTH]),
            .b           (in_b[g*WIDTH +: WIDTH]),
            .prod        (prod[g])
        );
    end

    always_comb begin
        lane_sum_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_sum_c = lane_sum_c + ACC_W'(prod[i]);
        end
    end

    // Element count with saturation at all-ones
    always_comb begin
        pop_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            pop_c = pop_c + PCW'(in_mask[i]);
        end
        cnt_sum_c = PCW'(out_count) + pop_c;
        cnt_sat_c = cnt_sum_c[PCW-1] ? {CNT_W{1'b1}} : cnt_sum_c[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_count   <= '0;
            out_len_err <= 1'b0;
            mode_r      <= 1'b0;
            v1          <= 1'b0;
            l1          <= 1'b0;
            v2          <= 1'b0;
            l2          <= 1'b0;
            lane_sum_r  <= '0;
        end else begin
            v1         <= accept_c;
            l1         <= accept_c && in_last;
            v2         <= v1;
            l2         <= l1;
            lane_sum_r <= lane_sum_c;

            if (v2) begin
                out_result <= out_result + lane_sum_r;
            end
            if (accept_c) begin
                out_count <= cnt_sat_c;
                if (cnt_sum_c > PCW'(MAX_LEN)) begin
                    out_len_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    in_ready <= !(accept_c && in_last);
                    if (accept_c) begin
                        mode_r <= in_signed;
                        state  <= in_last ? DRAIN : ACCUM;
                    end
                end
                ACCUM: begin
                    in_ready <= !(accept_c && in_last);
                    if (accept_c && in_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (v2 && l2) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    // Handshake frees the engine for the next vector
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid   <= 1'b0;
                        in_ready    <= 1'b1;
                        out_result  <= '0;
                        out_count   <= '0;
                        out_len_err <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_lanes.sv
// Randomized and directed bench for dot_product_lanes against an arithmetic reference model.
module tb_dot_product_lanes;

    localparam int unsigned W     = 8;
    localparam int unsigned L     = 4;
    localparam int unsigned ML    = 64;
    localparam int unsigned ACC_W = 2 * W + $clog2(ML) + 1;
    localparam int unsigned CNT_W = $clog2(ML) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [L*W-1:0]   in_a;
    logic [L*W-1:0]   in_b;
    logic [L-1:0]     in_mask;
    logic             in_last;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_result;
    logic [CNT_W-1:0] out_count;
    logic             out_len_err;

    dot_product_lanes dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_mask     (in_mask),
        .in_last     (in_last),
        .in_signed   (in_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_count   (out_count),
        .out_len_err (out_len_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [L*W-1:0] qa[$];
    logic [L*W-1:0] qb[$];
    logic [L-1:0]   qm[$];
    bit             qs[$];
    bit             qg[$];

    longint exp_res, exp_cnt, exp_err;
    longint got_res, got_cnt, got_err;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [L*W-1:0] pk(input int x0, input int x1, input int x2, input int x3);
        return {W'(x3), W'(x2), W'(x1), W'(x0)};
    endfunction

    task automatic clear_vec();
        qa.delete(); qb.delete(); qm.delete(); qs.delete(); qg.delete();
    endtask

    task automatic add_beat(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                            input logic [L-1:0] m, input bit s, input bit gap);
        qa.push_back(a); qb.push_back(b); qm.push_back(m); qs.push_back(s); qg.push_back(gap);
    endtask

    // Reference: plain integer dot product over the whole vector
    task automatic model();
        longint sum = 0;
        longint cnt = 0;
        bit sg = qs[0];
        for (int k = 0; k < qa.size(); k++) begin
            logic [L*W-1:0] ba = qa[k];
            logic [L*W-1:0] bb = qb[k];
            logic [L-1:0]   bm = qm[k];
            for (int i = 0; i < L; i++) begin
                if (bm[i]) begin
                    logic [W-1:0] ea = ba[i*W +: W];
                    logic [W-1:0] eb = bb[i*W +: W];
                    longint av = sg ? longint'($signed(ea)) : longint'(ea);
                    longint bv = sg ? longint'($signed(eb)) : longint'(eb);
                    sum += av * bv;
                    cnt++;
                end
            end
        end
        exp_res = sum & ((longint'(1) << ACC_W) - 1);
        exp_cnt = (cnt > 127) ? 127 : cnt;
        exp_err = (cnt > ML) ? 1 : 0;
    endtask

    task automatic drive_vec(input bit close);
        for (int k = 0; k < qa.size(); k++) begin
            int wt = 0;
            @(negedge clk);
            if (qg[k]) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_a      = qa[k];
            in_b      = qb[k];
            in_mask   = qm[k];
            in_signed = qs[k];
            in_last   = close && (k == qa.size() - 1);
            in_valid  = 1'b1;
            while (!in_ready && wt < 100) begin
                @(negedge clk);
                wt++;
            end
            if (wt >= 100) begin
                n_vec++;
                n_bad++;
                $display("FAIL ready_wait: in_ready stuck at 0 after %0d cycles", wt);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(input int hold);
        int lat = 0;
        model();
        while (!out_valid && lat < 50) begin
            check("in_ready_drain", in_ready, 0);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 2);
        got_res = out_result;
        got_cnt = out_count;
        got_err = out_len_err;
        check("result", got_res, exp_res);
        check("count", got_cnt, exp_cnt);
        check("len_err", got_err, exp_err);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            in_last  = 1'($urandom);
            in_a     = $urandom;
            in_b     = $urandom;
            in_mask  = 4'($urandom);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_result", out_result, exp_res);
            check("hold_count", out_count, exp_cnt);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_clr", out_valid, 0);
        check("in_ready_rel", in_ready, 1);
        check("result_clr", out_result, 0);
        check("count_clr", out_count, 0);
    endtask

    task automatic run_vec(input int hold);
        drive_vec(1'b1);
        collect(hold);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mask = '0;
        in_last = 1'b0; in_signed = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", out_result, 0);
        check("rst_count", out_count, 0);
        check("rst_len_err", out_len_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);

        // Single unsigned beat
        clear_vec();
        add_beat(pk(1, 2, 3, 4), pk(10, 1, 0, 2), 4'b1111, 1'b0, 1'b0);
        run_vec(0);
        check("t1_result", got_res, 20);
        check("t1_count", got_cnt, 4);

        // Three beats with one idle cycle before beat 2
        clear_vec();
        add_beat(pk(255, 255, 255, 255), pk(1, 1, 1, 1), 4'b1111, 1'b0, 1'b0);
        add_beat(pk(255, 255, 255, 255), pk(1, 1, 1, 1), 4'b1111, 1'b0, 1'b1);
        add_beat(pk(255, 255, 255, 255), pk(1, 1, 1, 1), 4'b1111, 1'b0, 1'b0);
        run_vec(1);
        check("t2_result", got_res, 3060);
        check("t2_count", got_cnt, 12);
        check("t2_err", got_err, 0);

        // Signed versus unsigned interpretation of the same bits
        clear_vec();
        add_beat(pk(8'h80, 8'hFF, 8'h7F, 0), pk(8'h80, 5, 8'hFF, 9), 4'b1111, 1'b1, 1'b0);
        run_vec(0);
        check("t3_signed", got_res, 16252);
        clear_vec();
        add_beat(pk(8'h80, 8'hFF, 8'h7F, 0), pk(8'h80, 5, 8'hFF, 9), 4'b1111, 1'b0, 1'b0);
        run_vec(0);
        check("t3_unsigned", got_res, 50044);
        clear_vec();
        add_beat(pk(8'h80, 8'hFF, 8'h7F, 0), pk(8'h80, 5, 8'hFF, 9), 4'b1111, 1'b1, 1'b0);
        add_beat(pk(8'h80, 8'hFF, 8'h7F, 0), pk(8'h80, 5, 8'hFF, 9), 4'b1111, 1'b0, 1'b0);
        run_vec(0);
        check("t3_toggle", got_res, 32504);

        // Partial mask and empty vector
        clear_vec();
        add_beat(pk(7, 7, 7, 7), pk(2, 2, 2, 2), 4'b0011, 1'b0, 1'b0);
        run_vec(0);
        check("t4_result", got_res, 28);
        check("t4_count", got_cnt, 2);
        clear_vec();
        add_beat(pk(9, 9, 9, 9), pk(9, 9, 9, 9), 4'b0000, 1'b0, 1'b0);
        run_vec(0);
        check("t4_empty_result", got_res, 0);
        check("t4_empty_count", got_cnt, 0);

        // Backpressure then a back-to-back vector
        clear_vec();
        add_beat(pk(1, 2, 3, 4), pk(10, 1, 0, 2), 4'b1111, 1'b0, 1'b0);
        run_vec(5);
        check("t5_held_result", got_res, 20);
        clear_vec();
        add_beat(pk(3, 3, 3, 3), pk(5, 5, 5, 5), 4'b1111, 1'b1, 1'b0);
        run_vec(0);
        check("t5_b2b_result", got_res, 60);

        // Length overflow and count saturation
        clear_vec();
        for (int k = 0; k < 17; k++) add_beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 4'b1111, 1'b0, 1'b0);
        run_vec(0);
        check("t6_result", got_res, 68);
        check("t6_count", got_cnt, 68);
        check("t6_err", got_err, 1);
        clear_vec();
        for (int k = 0; k < 40; k++) add_beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 4'b1111, 1'b0, 1'b0);
        run_vec(0);
        check("t6_sat_result", got_res, 160);
        check("t6_sat_count", got_cnt, 127);
        check("t6_sat_err", got_err, 1);

        // Reset in the middle of a vector
        clear_vec();
        add_beat(pk(5, 5, 5, 5), pk(5, 5, 5, 5), 4'b1111, 1'b0, 1'b0);
        add_beat(pk(5, 5, 5, 5), pk(5, 5, 5, 5), 4'b1111, 1'b0, 1'b0);
        drive_vec(1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("t7_rst_ready", in_ready, 0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t7_no_out", out_valid, 0);
        end
        check("t7_count_clr", out_count, 0);
        clear_vec();
        add_beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 4'b1111, 1'b0, 1'b0);
        run_vec(0);
        check("t7_result", got_res, 4);

        // Random vectors
        for (int v = 0; v < 40; v++) begin
            int nb = 1 + int'($urandom_range(5));
            clear_vec();
            for (int k = 0; k < nb; k++) begin
                add_beat($urandom, $urandom, 4'($urandom), 1'($urandom),
                         ($urandom_range(3) == 0));
            end
            run_vec(int'($urandom_range(3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
